decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage between fetch and the ALU.
// An accepted instruction spends one cycle in READ while the register file
// returns its operands, then sits in VALID with fully decoded, registered
// outputs until the ALU takes it.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_instr, in_pc carried with it
//   rf_raddr1/2           register-file read addresses (rs1, rs2)
//   rf_rdata1/2           register-file data, one cycle after the address
//   out_valid/out_ready   ALU handshake
//   operation             {instr[30] R, instr[30] SRLI/SRAI, funct3, opcode}
//   opr1, opr2, pc, imm   operands, instruction address, immediate
//   rd, rd_we, illegal    destination, write enable, unknown-opcode flag
module decode_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] opr1,
  output logic [XLEN-1:0] opr2,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  typedef enum logic [1:0] {StIdle, StRead, StValid} state_e;

  state_e          state_q, state_d;
  logic            accept;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      raddr1_q, raddr2_q;

  // Decoded fields of the latched instruction
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_r, is_ialu, is_load, is_store, is_br;
  logic            is_jal, is_jalr, is_lui, is_auipc;
  logic            legal, uses_rs1;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm, src1, src2, dec_opr1, dec_opr2;
  logic [11:0]     dec_op;
  logic            dec_we;

  assign accept = in_valid && in_ready;

  // The address goes out combinationally in the accept cycle so that a
  // synchronous register file returns data during READ; afterwards the
  // registered copy holds it steady.
  assign rf_raddr1 = accept ? in_instr[19:15] : raddr1_q;
  assign rf_raddr2 = accept ? in_instr[24:20] : raddr2_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StValid;
      StValid: if (out_ready) state_d = in_valid ? StRead : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StValid) && out_ready);
    out_valid = (state_q == StValid);
  end

  // Instruction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      pc_q     <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else if (accept) begin
      instr_q  <= in_instr;
      pc_q     <= in_pc;
      raddr1_q <= in_instr[19:15];
      raddr2_q <= in_instr[24:20];
    end
  end

  // Decode
  always_comb begin
    opcode   = instr_q[6:0];
    funct3   = instr_q[14:12];
    is_r     = (opcode == 7'b0110011);
    is_ialu  = (opcode == 7'b0010011);
    is_load  = (opcode == 7'b0000011);
    is_store = (opcode == 7'b0100011);
    is_br    = (opcode == 7'b1100011);
    is_jal   = (opcode == 7'b1101111);
    is_jalr  = (opcode == 7'b1100111);
    is_lui   = (opcode == 7'b0110111);
    is_auipc = (opcode == 7'b0010111);
    legal    = is_r || is_ialu || is_load || is_store || is_br ||
               is_jal || is_jalr || is_lui || is_auipc;
    uses_rs1 = is_r || is_ialu || is_load || is_store || is_br || is_jalr;

    imm32 = '0;
    if (is_ialu || is_load || is_jalr) begin
      imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
    end else if (is_store) begin
      imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    end else if (is_br) begin
      imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
               instr_q[11:8], 1'b0};
    end else if (is_lui || is_auipc) begin
      imm32 = {instr_q[31:12], 12'b0};
    end else if (is_jal) begin
      imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
               instr_q[30:21], 1'b0};
    end
    dec_imm = XLEN'($signed(imm32));

    // x0 reads as zero regardless of what the register file returns
    src1 = (instr_q[19:15] == 5'd0) ? '0 : rf_rdata1;
    src2 = (instr_q[24:20] == 5'd0) ? '0 : rf_rdata2;

    dec_op   = {is_r && instr_q[30],
                is_ialu && (funct3 == 3'b101) && instr_q[30],
                uses_rs1 ? funct3 : 3'b000,
                opcode};
    dec_opr1 = uses_rs1 ? src1 : '0;
    dec_opr2 = (is_r || is_br) ? src2 : dec_imm;  // dec_imm is 0 when illegal
    dec_we   = legal && !is_store && !is_br && (instr_q[11:7] != 5'd0);
  end

  // Output registers, loaded in READ and held through VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      operation <= '0;
      opr1      <= '0;
      opr2      <= '0;
      pc        <= '0;
      imm       <= '0;
      rd        <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else if (state_q == StRead) begin
      operation <= dec_op;
      opr1      <= dec_opr1;
      opr2      <= dec_opr2;
      pc        <= pc_q;
      imm       <= dec_imm;
      rd        <= instr_q[11:7];
      rd_we     <= dec_we;
      illegal   <= !legal;
    end
  end

endmodule
